inst_rom_loader: RTL and testbench

//  Instruction-memory side of the NJU_MIPS core. Consumes rom_ce_o/rom_addr_o and drives rom_data_i.
//  At boot it fills a word array from a byte stream over a valid/ready load port, holding the core in reset.

---
 rtl/inst_rom_loader_pkg.sv | 20 ++
 rtl/inst_rom_loader_byte_packer.sv | 48 ++++
 rtl/inst_rom_loader.sv | 112 +++++++++++
 tb/tb_inst_rom_loader.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_rom_loader_pkg.sv
// Shared types and constants for the boot-time instruction ROM loader.
package inst_rom_loader_pkg;

    localparam int unsigned REGBUS = 32;
    localparam int unsigned BYTE_W = 8;
    localparam logic [REGBUS-1:0] ZEROWORD = '0;

    typedef enum logic [1:0] {
        LD_IDLE = 2'd0,
        LD_LOAD = 2'd1,
        LD_DONE = 2'd2,
        LD_ERR  = 2'd3
    } ld_state_e;

    typedef struct packed {
        logic [BYTE_W-1:0] data;
        logic              last;
    } ld_beat_t;

endpackage

// File: rtl/inst_rom_loader_byte_packer.sv
// Packs a big-endian byte stream into 32-bit words; a last byte flushes a zero-padded word.
module rom_byte_packer
    import inst_rom_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  ld_beat_t          beat,
    input  logic              accept,
    output logic [1:0]        byte_idx,
    output logic [REGBUS-1:0] word_c,
    output logic              word_valid_c
);

    logic [23:0] partial;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_idx <= 2'd0;
            partial  <= 24'd0;
        end else if (accept) begin
            if (word_valid_c) begin
                byte_idx <= 2'd0;
                partial  <= 24'd0;
            end else begin
                byte_idx <= byte_idx + 2'd1;
                case (byte_idx)
                    2'd0:    partial[23:16] <= beat.data;
                    2'd1:    partial[15:8]  <= beat.data;
                    2'd2:    partial[7:0]   <= beat.data;
                    default: ;
                endcase
            end
        end
    end

    // Current byte merged with the held bytes; unfilled low lanes stay zero.
    always_comb begin
        word_c = ZEROWORD;
        case (byte_idx)
            2'd0:    word_c = {beat.data, 24'd0};
            2'd1:    word_c = {partial[23:16], beat.data, 16'd0};
            2'd2:    word_c = {partial[23:8], beat.data, 8'd0};
            default: word_c = {partial, beat.data};
        endcase
        word_valid_c = accept & ((byte_idx == 2'd3) | beat.last);
    end

endmodule

// File: rtl/inst_rom_loader.sv
// Instruction memory for the core: boot-loads an image from a byte stream, then serves fetches.
module inst_rom_loader
    import inst_rom_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_valid,
    input  logic [7:0]        ld_byte,
    input  logic              ld_last,
    output logic              ld_ready,
    input  logic              rom_ce,
    input  logic [REGBUS-1:0] rom_addr,
    output logic [REGBUS-1:0] rom_data,
    output logic              core_rst,
    output logic              load_done,
    output logic [ADDR_W:0]   load_words,
    output logic              err
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    ld_state_e         state;
    logic [REGBUS-1:0] mem [DEPTH];

    logic              accept_c;
    logic              loading_c;
    logic              overflow_c;
    logic              pack_accept_c;
    logic [1:0]        byte_idx;
    logic [REGBUS-1:0] word_c;
    logic              word_valid_c;
    logic [ADDR_W-1:0] rom_idx_c;
    ld_beat_t          beat_c;
    logic              unused_addr_lsb;

    always_comb begin
        beat_c        = '{data: ld_byte, last: ld_last};
        loading_c     = (state == LD_IDLE) || (state == LD_LOAD);
        accept_c      = ld_valid & ld_ready;
        // A byte that would open a word past the last slot overflows the image.
        overflow_c    = accept_c & loading_c & (byte_idx == 2'd0)
                        & (load_words == CNT_W'(DEPTH));
        pack_accept_c = accept_c & loading_c & ~overflow_c;
    end

    rom_byte_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .beat         (beat_c),
        .accept       (pack_accept_c),
        .byte_idx     (byte_idx),
        .word_c       (word_c),
        .word_valid_c (word_valid_c)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= LD_IDLE;
            ld_ready   <= 1'b0;
            core_rst   <= 1'b1;
            load_done  <= 1'b0;
            err        <= 1'b0;
            load_words <= '0;
        end else begin
            ld_ready <= (state != LD_DONE);
            // Core leaves reset one cycle after DONE is reached.
            core_rst <= (state != LD_DONE);
            case (state)
                LD_IDLE, LD_LOAD: begin
                    if (accept_c) begin
                        if (overflow_c) begin
                            state <= LD_ERR;
                            err   <= 1'b1;
                        end else if (ld_last) begin
                            state     <= LD_DONE;
                            load_done <= 1'b1;
                            ld_ready  <= 1'b0;
                        end else begin
                            state <= LD_LOAD;
                        end
                    end
                end
                default: ;
            endcase
            if (word_valid_c) begin
                load_words <= load_words + CNT_W'(1);
            end
        end
    end

    // Array is deliberately not reset; load_words gates visibility instead.
    always_ff @(posedge clk) begin
        if (word_valid_c) begin
            mem[load_words[ADDR_W-1:0]] <= word_c;
        end
    end

    always_comb begin
        rom_idx_c       = rom_addr[ADDR_W+1:2];
        unused_addr_lsb = ^rom_addr[1:0];
        rom_data        = ZEROWORD;
        if (!core_rst && rom_ce
            && (rom_addr[REGBUS-1:ADDR_W+2] == '0)
            && ({1'b0, rom_idx_c} < load_words)) begin
            rom_data = mem[rom_idx_c];
        end
    end

endmodule

// File: tb/tb_inst_rom_loader.sv
// Scoreboard bench for inst_rom_loader: a 1024-word instance and a 4-word instance.
module tb_inst_rom_loader;

    typedef struct {
        string       name;
        logic [14:0] exp;
    } stat_t;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } fet_t;

    logic        clk = 1'b0;
    logic        rst       [2];
    logic        ld_valid  [2];
    logic [7:0]  ld_byte   [2];
    logic        ld_last   [2];
    logic        ld_ready  [2];
    logic        rom_ce    [2];
    logic [31:0] rom_addr  [2];
    logic [31:0] rom_data  [2];
    logic        core_rst  [2];
    logic        load_done [2];
    logic        err       [2];
    logic [10:0] lw_a;
    logic [2:0]  lw_b;

    always #5 clk = ~clk;

    inst_rom_loader #(.ADDR_W(10)) dut_a (
        .clk(clk), .rst(rst[0]), .ld_valid(ld_valid[0]), .ld_byte(ld_byte[0]),
        .ld_last(ld_last[0]), .ld_ready(ld_ready[0]), .rom_ce(rom_ce[0]),
        .rom_addr(rom_addr[0]), .rom_data(rom_data[0]), .core_rst(core_rst[0]),
        .load_done(load_done[0]), .load_words(lw_a), .err(err[0])
    );

    inst_rom_loader #(.ADDR_W(2)) dut_b (
        .clk(clk), .rst(rst[1]), .ld_valid(ld_valid[1]), .ld_byte(ld_byte[1]),
        .ld_last(ld_last[1]), .ld_ready(ld_ready[1]), .rom_ce(rom_ce[1]),
        .rom_addr(rom_addr[1]), .rom_data(rom_data[1]), .core_rst(core_rst[1]),
        .load_done(load_done[1]), .load_words(lw_b), .err(err[1])
    );

    int total = 0;
    int bad   = 0;

    // Reference model: byte count, visible words, flags, image contents.
    int          nb     [2];
    int          words  [2];
    bit          mdone  [2];
    bit          merr   [2];
    bit          in_rst [2];
    int          age    [2];
    logic [31:0] mm     [2][1024];

    bit    sreq [2];
    bit    freq [2];
    stat_t sq0[$], sq1[$];
    fet_t  fq0[$], fq1[$];

    function automatic int cap(int s);
        return (s == 0) ? 1024 : 4;
    endfunction

    function automatic int aw(int s);
        return (s == 0) ? 10 : 2;
    endfunction

    function automatic bit exp_crst(int s);
        return in_rst[s] || merr[s] || !(mdone[s] && age[s] >= 2);
    endfunction

    function automatic logic [31:0] exp_fetch(int s, logic ce, logic [31:0] addr);
        int idx;
        if (in_rst[s] || !ce || exp_crst(s)) return 32'd0;
        if ((addr >> (aw(s) + 2)) != 32'd0) return 32'd0;
        idx = int'((addr >> 2) & 32'(cap(s) - 1));
        if (idx >= words[s]) return 32'd0;
        return mm[s][idx];
    endfunction

    task automatic model_reset(int s);
        nb[s] = 0; words[s] = 0; mdone[s] = 0; merr[s] = 0; age[s] = 0; in_rst[s] = 1;
    endtask

    task automatic model_accept(int s, logic [7:0] b, bit last);
        int w;
        int k;
        if (merr[s] || mdone[s]) return;
        w = nb[s] / 4;
        k = nb[s] % 4;
        if (k == 0 && w == cap(s)) begin
            merr[s] = 1;
            return;
        end
        if (k == 0) mm[s][w] = 32'd0;
        mm[s][w][31 - 8 * k -: 8] = b;
        nb[s]++;
        if (nb[s] % 4 == 0) words[s] = nb[s] / 4;
        if (last) begin
            words[s] = (nb[s] + 3) / 4;
            mdone[s] = 1;
            age[s]   = 0;
        end
    endtask

    task automatic step();
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            ld_valid[s] = 1'b0;
            ld_last[s]  = 1'b0;
            rom_ce[s]   = 1'b0;
            sreq[s]     = 1'b0;
            freq[s]     = 1'b0;
            if (mdone[s] && age[s] < 2) age[s]++;
        end
    endtask

    task automatic send(int s, logic [7:0] b, bit last);
        int t;
        t = 0;
        step();
        while (!ld_ready[s]) begin
            if (t == 200) begin
                total++; bad++;
                $display("FAIL ld_ready_timeout dut%0d: got ld_ready=0 want 1", s);
                return;
            end
            step();
            t++;
        end
        ld_valid[s] = 1'b1;
        ld_byte[s]  = b;
        ld_last[s]  = last;
        model_accept(s, b, last);
    endtask

    task automatic poke(int s, logic [7:0] b);
        step();
        ld_valid[s] = 1'b1;
        ld_byte[s]  = b;
        ld_last[s]  = 1'b1;
    endtask

    task automatic chk_stat(int s, string name);
        stat_t e;
        step();
        e.name = name;
        e.exp  = {merr[s], mdone[s], exp_crst(s), !in_rst[s] && !mdone[s], 11'(words[s])};
        if (s == 0) sq0.push_back(e); else sq1.push_back(e);
        sreq[s] = 1'b1;
    endtask

    task automatic fetch(int s, logic [31:0] addr, logic ce, string name);
        fet_t e;
        step();
        rom_ce[s]   = ce;
        rom_addr[s] = addr;
        e.name = name;
        e.exp  = exp_fetch(s, ce, addr);
        if (s == 0) fq0.push_back(e); else fq1.push_back(e);
        freq[s] = 1'b1;
    endtask

    task automatic reset_dut(int s);
        step();
        rst[s] = 1'b0;
        model_reset(s);
        chk_stat(s, "reset_state");
        step();
        rst[s] = 1'b1;
        in_rst[s] = 0;
    endtask

    task automatic load_img(int s, logic [7:0] img[$], bit with_last, int gap);
        for (int i = 0; i < img.size(); i++) begin
            send(s, img[i], with_last && (i == img.size() - 1));
            if (i != img.size() - 1)
                for (int g = 0; g < gap; g++) fetch(s, 32'h0, 1'b1, "fetch_during_load");
        end
    endtask

    // Monitor: compares whenever a status or fetch strobe is presented.
    always @(negedge clk) begin
        stat_t       se;
        fet_t        fe;
        logic [14:0] sact;
        #1;
        for (int s = 0; s < 2; s++) begin
            if (sreq[s]) begin
                total++;
                if ((s == 0 ? sq0.size() : sq1.size()) == 0) begin
                    bad++;
                    $display("FAIL status_queue_empty dut%0d", s);
                end else begin
                    se   = (s == 0) ? sq0.pop_front() : sq1.pop_front();
                    sact = (s == 0) ? {err[0], load_done[0], core_rst[0], ld_ready[0], lw_a}
                                    : {err[1], load_done[1], core_rst[1], ld_ready[1], 8'd0, lw_b};
                    if (sact !== se.exp) begin
                        bad++;
                        $display("FAIL %s dut%0d: got err/done/crst/rdy/words=%b/%b/%b/%b/%0d want %b/%b/%b/%b/%0d",
                                 se.name, s, sact[14], sact[13], sact[12], sact[11], sact[10:0],
                                 se.exp[14], se.exp[13], se.exp[12], se.exp[11], se.exp[10:0]);
                    end
                end
            end
            if (freq[s]) begin
                total++;
                if ((s == 0 ? fq0.size() : fq1.size()) == 0) begin
                    bad++;
                    $display("FAIL fetch_queue_empty dut%0d", s);
                end else begin
                    fe = (s == 0) ? fq0.pop_front() : fq1.pop_front();
                    if (rom_data[s] !== fe.exp) begin
                        bad++;
                        $display("FAIL %s dut%0d addr=%h: got %h want %h",
                                 fe.name, s, rom_addr[s], rom_data[s], fe.exp);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0]  img[$];
        logic [31:0] a;
        int          n;
        for (int s = 0; s < 2; s++) begin
            rst[s] = 1'b0; ld_valid[s] = 1'b0; ld_byte[s] = 8'd0; ld_last[s] = 1'b0;
            rom_ce[s] = 1'b0; rom_addr[s] = 32'd0;
            model_reset(s);
        end
        chk_stat(0, "reset_state");
        chk_stat(1, "reset_state");
        step();
        rst[0] = 1'b1; rst[1] = 1'b1; in_rst[0] = 0; in_rst[1] = 0;

        // Two-word image, then fetch corner cases and ignored bytes in DONE.
        img = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
        load_img(0, img, 1, 0);
        chk_stat(0, "done_core_still_rst");
        chk_stat(0, "core_released");
        fetch(0, 32'h4, 1'b1, "word1");
        fetch(0, 32'h0, 1'b1, "word0");
        fetch(0, 32'h4, 1'b0, "ce_low");
        fetch(0, 32'h1000, 1'b1, "addr_out_of_range");
        fetch(0, 32'h3, 1'b1, "low_bits_ignored");
        fetch(0, 32'h8, 1'b1, "beyond_load_words");
        for (int i = 0; i < 3; i++) poke(0, 8'hF0 + 8'(i));
        chk_stat(0, "done_ignores_bytes");
        fetch(0, 32'h0, 1'b1, "word0_after_poke");

        // Partial last word is zero-padded.
        reset_dut(0);
        img = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        load_img(0, img, 1, 0);
        chk_stat(0, "padded_done");
        fetch(0, 32'h0, 1'b1, "pad_w0");
        fetch(0, 32'h4, 1'b1, "pad_w1");
        fetch(0, 32'h8, 1'b1, "pad_w2_hidden");

        // Same image with idle cycles between bytes.
        reset_dut(0);
        img = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
        load_img(0, img, 1, 1);
        chk_stat(0, "gapped_done");
        chk_stat(0, "gapped_released");
        fetch(0, 32'h4, 1'b1, "gapped_word1");

        // Reset mid-load, then a fresh one-word image.
        reset_dut(0);
        img = '{8'h01, 8'h02, 8'h03};
        load_img(0, img, 0, 0);
        reset_dut(0);
        img = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        load_img(0, img, 1, 0);
        chk_stat(0, "reload_done");
        chk_stat(0, "reload_released");
        fetch(0, 32'h0, 1'b1, "reload_w0");
        fetch(0, 32'h4, 1'b1, "reload_stale_hidden");

        // Small array: overflow, draining in ERR, exact fill, overflow beats last.
        img.delete();
        for (int i = 1; i <= 17; i++) img.push_back(8'(i));
        load_img(1, img, 0, 0);
        chk_stat(1, "overflow_err");
        send(1, 8'h55, 1'b0);
        send(1, 8'h66, 1'b1);
        chk_stat(1, "err_drains");
        fetch(1, 32'h0, 1'b1, "err_fetch_zero");
        reset_dut(1);
        img.delete();
        for (int i = 1; i <= 16; i++) img.push_back(8'(i));
        load_img(1, img, 1, 0);
        chk_stat(1, "full_done");
        chk_stat(1, "full_released");
        fetch(1, 32'hC, 1'b1, "full_last_word");
        fetch(1, 32'h10, 1'b1, "small_out_of_range");
        reset_dut(1);
        img.push_back(8'h99);
        load_img(1, img, 1, 0);
        chk_stat(1, "overflow_overrides_last");

        // Randomized images and fetches on both instances.
        for (int it = 0; it < 10; it++) begin
            int s;
            s = (it < 6) ? 0 : 1;
            reset_dut(s);
            n = (s == 0) ? $urandom_range(1, 40) : $urandom_range(1, 20);
            img.delete();
            for (int i = 0; i < n; i++) img.push_back(8'($urandom));
            load_img(s, img, 1, $urandom_range(0, 1));
            chk_stat(s, "rnd_done");
            chk_stat(s, "rnd_settled");
            for (int k = 0; k < 6; k++) begin
                a = (32'($urandom_range(0, words[s] + 1)) << 2) | 32'($urandom_range(0, 3));
                if ($urandom_range(0, 5) == 0) a = a | (32'h1 << $urandom_range(aw(s) + 2, 31));
                fetch(s, a, 1'($urandom_range(0, 7) != 0), "rnd_fetch");
            end
        end

        repeat (3) step();
        total++;
        if (sq0.size() + sq1.size() + fq0.size() + fq1.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending want 0",
                     sq0.size() + sq1.size() + fq0.size() + fq1.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
